// File: rtl/indexed_accum_table.sv
// indexed_accum_table: indexed write/accumulate table with registered reads and a sequential sum engine
module indexed_accum_table #(
  parameter int DW = 32,
  parameter int NUM_INP = 8,
  parameter int AW = 3,
  parameter int SW = 35
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          wr_mode,
  input  logic [AW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          sum_start,
  output logic          sum_busy,
  output logic          sum_valid,
  output logic [SW-1:0] sum_data
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_INP*DW-1:0] mem_q, mem_d;
  logic [DW-1:0] rd_data_q, rd_data_d, rd_sel, cur;
  logic rd_valid_q, rd_valid_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] acc_q, acc_d, sum_data_q, sum_data_d;
  always_comb begin
    mem_d = mem_q;
    rd_sel = '0;
    cur = '0;
    for (int i = 0; i < NUM_INP; i++) begin
      if (wr_en && 32'(wr_idx) == i) mem_d[i*DW +: DW] = wr_mode ? mem_q[i*DW +: DW] + wr_data : wr_data;
      if (32'(rd_idx) == i) rd_sel = mem_q[i*DW +: DW];
      if (32'(ptr_q) == i) cur = mem_q[i*DW +: DW];
    end
    if (clr) mem_d = '0;
    rd_data_d = rd_en ? rd_sel : rd_data_q;
    rd_valid_d = rd_en;
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    acc_d = acc_q;
    sum_data_d = sum_data_q;
    if (state_q == IDLE && sum_start) begin
      state_d = ACCUM;
      ptr_d = '0;
      acc_d = '0;
    end else if (state_q == ACCUM) begin
      acc_d = acc_q + SW'(cur);
      ptr_d = ptr_q + 1'b1;
      if (32'(ptr_q) == NUM_INP - 1) begin
        state_d = DONE;
        sum_data_d = acc_d;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (clr && state_q != IDLE) begin
      state_d = IDLE;
      sum_data_d = sum_data_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mem_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
      ptr_q <= '0;
      acc_q <= '0;
      sum_data_q <= '0;
    end else begin
      state_q <= state_d;
      mem_q <= mem_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ptr_q <= ptr_d;
      acc_q <= acc_d;
      sum_data_q <= sum_data_d;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign sum_busy = state_q != IDLE;
  assign sum_valid = state_q == DONE;
  assign sum_data = sum_data_q;
endmodule
